motor_position_controller: RTL and testbench

Closed-loop sequencer for the single-axis motor, driven from the hall-sensor angle tracker. Accepts move and home commands over a valid/ready handshake. Chooses the shortest rotation direction, drives enable, PWM and direction to the motor bridge, and holds the tracker's clear line during homing. Reports busy, a one-cycle done pulse and a sticky fault (stall or retry exhaustion) to the host-side register block.

---
 rtl/motor_position_controller.sv | 189 ++++++++++++++++++
 tb/tb_motor_position_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_position_controller.sv
// Single-axis closed-loop position sequencer: move/home commands in, bridge drive out.
// Latency: a command is accepted in IDLE and the drive outputs change on the next clock edge.
// Backpressure: cmd_ready is high only in IDLE, so a new command waits until the current one ends.
// Ports: clk/reset (async active-low); cmd_valid/cmd_ready/cmd_home/cmd_target command channel;
//   angle/index tracker and home-sensor inputs (async); abort stop request;
//   motor_en/pwm/clockwise bridge drive; trk_reset tracker clear (active-low);
//   busy/done/fault host status.
module motor_position_controller #(
  parameter int         TOL           = 4,
  parameter int         SLOW_BAND     = 64,
  parameter logic [7:0] FAST_DUTY     = 8'd200,
  parameter logic [7:0] SLOW_DUTY     = 8'd80,
  parameter int         SETTLE_CYCLES = 1000,
  parameter int         STALL_CYCLES  = 100000,
  parameter int         MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_home,
  input  logic [11:0] cmd_target,
  input  logic [11:0] angle,
  input  logic        index,
  input  logic        abort,
  output logic        motor_en,
  output logic        pwm,
  output logic        clockwise,
  output logic        trk_reset,
  output logic        busy,
  output logic        done,
  output logic        fault
);

  localparam int DW = $clog2(SETTLE_CYCLES + 1);
  localparam int SW = $clog2(STALL_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [11:0] TOL_L  = 12'(TOL);
  localparam logic [11:0] BAND_L = 12'(SLOW_BAND);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE, S_SETTLE, S_HOME, S_ZERO, S_DONE, S_FAULT
  } state_t;

  state_t state, state_n;

  logic [11:0]   ang_a, ang_b, ang_s, ang_q, tgt;
  logic          idx_s1, idx_s2, idx_s3;
  logic [DW-1:0] dwell;
  logic [SW-1:0] stall_cnt;
  logic [RW-1:0] retry, retry_d;
  logic [7:0]    pwm_cnt, duty, duty_d;
  logic          en_d, cw_d, trk_d, busy_d, done_d, fault_d;

  logic          accept;
  logic [11:0]   tgt_eff, err, mag;
  logic          cw_now, at_tgt, ang_chg, idx_chg, idx_rise;
  logic          settle_exp, zero_exp, stall_hit, driving;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  // On the accept cycle tgt is not yet loaded, so steer with the incoming target.
  assign tgt_eff = accept ? cmd_target : tgt;
  assign err     = tgt_eff - ang_s;
  // err == 2048 has bit 11 set; 0 - 2048 wraps back to 2048, so the tie needs no special case.
  assign mag     = err[11] ? (12'd0 - err) : err;
  assign cw_now  = (err <= 12'd2048);
  assign at_tgt  = (mag <= TOL_L);

  assign ang_chg    = (ang_s != ang_q);
  assign idx_chg    = (idx_s2 != idx_s3);
  assign idx_rise   = idx_s2 && !idx_s3;
  assign settle_exp = (dwell == DW'(SETTLE_CYCLES - 1));
  assign zero_exp   = (dwell == DW'(1));
  assign stall_hit  = (stall_cnt >= SW'(STALL_CYCLES));
  assign driving    = (state == S_MOVE) || (state == S_HOME);

  assign pwm = motor_en && (pwm_cnt < duty);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    state_n = state;
    if (state != S_IDLE && abort) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (accept) state_n = cmd_home ? S_HOME : S_MOVE;
        S_MOVE:   if (stall_hit) state_n = S_FAULT;
                  else if (at_tgt) state_n = S_SETTLE;
        S_SETTLE: if (settle_exp) begin
                    if (at_tgt)                     state_n = S_DONE;
                    else if (retry < RW'(MAX_RETRY)) state_n = S_MOVE;
                    else                            state_n = S_FAULT;
                  end
        S_HOME:   if (stall_hit) state_n = S_FAULT;
                  else if (idx_rise) state_n = S_ZERO;
        S_ZERO:   if (zero_exp) state_n = S_DONE;
        S_DONE:   state_n = S_IDLE;
        S_FAULT:  state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // Output logic: values for the next state, registered below so the bridge never sees glitches
  always_comb begin
    en_d    = (state_n == S_MOVE) || (state_n == S_HOME);
    cw_d    = clockwise;
    duty_d  = duty;
    trk_d   = (state_n != S_ZERO);
    busy_d  = (state_n != S_IDLE);
    done_d  = (state_n == S_DONE);
    fault_d = fault;
    retry_d = retry;
    if (state_n == S_HOME) begin
      cw_d   = 1'b0;
      duty_d = SLOW_DUTY;
    end else if (state_n == S_MOVE) begin
      cw_d   = cw_now;
      duty_d = (mag <= BAND_L) ? SLOW_DUTY : FAST_DUTY;
    end
    if (accept) begin
      fault_d = 1'b0;
      retry_d = '0;
    end else if (state == S_SETTLE && state_n == S_MOVE) begin
      retry_d = retry + 1'b1;
    end
    if (state_n == S_FAULT) fault_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      motor_en  <= 1'b0;
      clockwise <= 1'b1;
      trk_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      duty      <= '0;
      retry     <= '0;
      pwm_cnt   <= '0;
      tgt       <= '0;
      dwell     <= '0;
      stall_cnt <= '0;
      ang_a     <= '0;
      ang_b     <= '0;
      ang_s     <= '0;
      ang_q     <= '0;
      idx_s1    <= 1'b0;
      idx_s2    <= 1'b0;
      idx_s3    <= 1'b0;
    end else begin
      motor_en  <= en_d;
      clockwise <= cw_d;
      trk_reset <= trk_d;
      busy      <= busy_d;
      done      <= done_d;
      fault     <= fault_d;
      duty      <= duty_d;
      retry     <= retry_d;
      pwm_cnt   <= pwm_cnt + 8'd1;
      if (accept) tgt <= cmd_target;
      // Two matching consecutive samples reject a torn multi-bit transition.
      ang_a <= angle;
      ang_b <= ang_a;
      if (ang_a == ang_b) ang_s <= ang_a;
      ang_q  <= ang_s;
      idx_s1 <= index;
      idx_s2 <= idx_s1;
      idx_s3 <= idx_s2;
      // Dwell timer restarts on every state entry and only runs where a timed wait exists.
      if (state_n != state || !(state == S_SETTLE || state == S_ZERO)) dwell <= '0;
      else                                                           dwell <= dwell + 1'b1;
      // Stall timer: any observed motion (or index activity while homing) restarts it.
      if (driving && state_n == state && !ang_chg && !(state == S_HOME && idx_chg))
        stall_cnt <= stall_cnt + 1'b1;
      else
        stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_motor_position_controller.sv
// Self-checking bench for motor_position_controller: directed moves, homing, stall, retry, abort, reset.
// Completion events (done pulse / fault rise) are checked by a scoreboard monitor against a queue.
// Level outputs (direction, duty, dwell lengths) are checked inline by the stimulus process.
module tb_motor_position_controller;

  localparam int STALL = 2000;
  localparam int SETTLE = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_home = 1'b0;
  logic [11:0] cmd_target = '0;
  logic [11:0] angle = '0;
  logic        index = 1'b0;
  logic        abort = 1'b0;
  logic        motor_en, pwm, clockwise, trk_reset, busy, done, fault;

  int checks = 0;
  int errors = 0;
  int exp_q[$];      // 1 = done pulse expected, 2 = fault expected
  logic fault_q = 1'b0;

  motor_position_controller #(
    .TOL(4), .SLOW_BAND(64), .FAST_DUTY(8'd200), .SLOW_DUTY(8'd80),
    .SETTLE_CYCLES(SETTLE), .STALL_CYCLES(STALL), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_home(cmd_home), .cmd_target(cmd_target), .angle(angle), .index(index),
    .abort(abort), .motor_en(motor_en), .pwm(pwm), .clockwise(clockwise),
    .trk_reset(trk_reset), .busy(busy), .done(done), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_cmd(input logic home, input logic [11:0] tgt);
    cmd_valid  = 1'b1;
    cmd_home   = home;
    cmd_target = tgt;
    check("cmd_ready_before_accept", int'(cmd_ready), 1);
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic measure_duty(output int n);
    n = 0;
    repeat (256) begin
      if (pwm) n++;
      step(1);
    end
  endtask

  // Scoreboard monitor: every done pulse or fault rise must match the head of the queue.
  always @(negedge clk) begin
    if (reset) begin
      int kind;
      kind = 0;
      if (done) kind = 1;
      else if (fault && !fault_q) kind = 2;
      if (kind != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
          check("event_kind", kind, exp_q.pop_front());
        end
        check("motor_off_at_event", int'(motor_en), 0);
      end
    end
    fault_q <= fault;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, pw, retries;

    // ---- Test 1: reset state, fast/slow duty, settle dwell, single done ----
    angle = 12'd100;
    #12;
    check("reset_outputs", int'({motor_en, pwm, clockwise, trk_reset, busy, done, fault, cmd_ready}),
          int'(8'b0011_0001));
    @(negedge clk);
    reset = 1'b1;
    step(5);
    exp_q.push_back(1);
    send_cmd(1'b0, 12'd600);
    check("t1_cmd_ready_drops", int'(cmd_ready), 0);
    check("t1_busy", int'(busy), 1);
    check("t1_cw", int'(clockwise), 1);
    measure_duty(n);
    check("t1_fast_duty", n, 200);
    angle = 12'd540;
    step(5);
    measure_duty(n);
    check("t1_slow_duty", n, 80);
    angle = 12'd598;
    n = 0;
    while (motor_en && n < 20) begin step(1); n++; end
    check("t1_enter_settle", int'(motor_en), 0);
    n = 0;
    while (!done && n < 1100) begin step(1); n++; end
    check("t1_settle_cycles", n, SETTLE);
    step(1);
    check("t1_done_one_cycle", int'(done), 0);
    check("t1_busy_cleared", int'(busy), 0);

    // ---- Test 2: wrap-around direction and 2048 tie ----
    angle = 12'd10;
    step(5);
    send_cmd(1'b0, 12'd4090);
    check("t2_wrap_ccw", int'(clockwise), 0);
    measure_duty(n);
    check("t2_wrap_slow_duty", n, 80);
    abort = 1'b1; step(1); abort = 1'b0;
    angle = 12'd0;
    step(5);
    send_cmd(1'b0, 12'd2048);
    check("t2_tie_cw", int'(clockwise), 1);
    measure_duty(n);
    check("t2_tie_fast_duty", n, 200);
    abort = 1'b1; step(1); abort = 1'b0;
    check("t2_abort_idle", int'({busy, motor_en, fault}), 0);

    // ---- Test 3: homing with index pulse ----
    exp_q.push_back(1);
    send_cmd(1'b1, 12'd0);
    bad = 0; pw = 0;
    for (int i = 0; i < 500; i++) begin
      if (i % 4 == 0) angle = angle - 12'd1;
      if (!motor_en || clockwise) bad++;
      if (i >= 100 && i < 356 && pwm) pw++;
      step(1);
    end
    check("t3_home_drive_ccw", bad, 0);
    check("t3_home_duty", pw, 80);
    index = 1'b1;
    n = 0;
    while (trk_reset && n < 20) begin step(1); n++; end
    check("t3_trk_reset_low", int'(trk_reset), 0);
    n = 0; bad = 0;
    while (!trk_reset && n < 10) begin
      if (motor_en) bad++;
      step(1); n++;
    end
    check("t3_trk_reset_cycles", n, 2);
    check("t3_motor_off_in_zero", bad, 0);
    n = 0;
    while (busy && n < 10) begin step(1); n++; end
    check("t3_home_complete", int'(busy), 0);
    index = 1'b0;

    // ---- Test 4: stall fault, then clear on next command (already-at-target move) ----
    angle = 12'd0;
    step(5);
    exp_q.push_back(2);
    send_cmd(1'b0, 12'd1000);
    n = 0;
    while (!fault && n < 3000) begin step(1); n++; end
    check("t4_stall_fault_set", int'(fault), 1);
    check("t4_stall_at_limit", int'(n >= STALL && n <= STALL + 2), 1);
    step(2);
    check("t4_fault_sticky", int'({fault, busy, motor_en}), int'(3'b100));
    exp_q.push_back(1);
    send_cmd(1'b0, 12'd2);
    check("t4_fault_cleared", int'(fault), 0);
    check("t4_one_drive_cycle", int'(motor_en), 1);
    step(1);
    check("t4_drive_stops", int'(motor_en), 0);
    n = 0;
    while (!done && n < 1100) begin step(1); n++; end
    check("t4_done_reached", int'(done), 1);
    step(2);

    // ---- Test 5: overshoot retries then fault; abort mid-move ----
    angle = 12'd580;
    step(5);
    exp_q.push_back(2);
    send_cmd(1'b0, 12'd600);
    angle = 12'd600;
    retries = 0; bad = 0;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      while (motor_en && n < 50) begin step(1); n++; end
      angle = 12'd620;
      n = 0;
      while (!motor_en && !fault && n < 1100) begin step(1); n++; end
      if (fault || !motor_en) break;
      retries++;
      if (clockwise) bad++;
      angle = 12'd600;
    end
    check("t5_retry_count", retries, 3);
    check("t5_retry_ccw", bad, 0);
    check("t5_retry_fault", int'(fault), 1);
    step(2);
    angle = 12'd0;
    step(5);
    send_cmd(1'b0, 12'd1000);
    step(10);
    abort = 1'b1; step(1); abort = 1'b0;
    check("t5_abort_outputs", int'({busy, motor_en, done, fault}), 0);
    step(5);
    check("t5_abort_no_fault", int'(fault), 0);

    // ---- Test 6: async reset mid-move with pwm high; torn angle sample ----
    send_cmd(1'b0, 12'd1000);
    n = 0;
    while (!pwm && n < 300) begin step(1); n++; end
    check("t6_pwm_high", int'(pwm), 1);
    #2 reset = 1'b0;
    #1 check("t6_async_reset_outputs",
             int'({motor_en, pwm, clockwise, trk_reset, busy, done, fault, cmd_ready}),
             int'(8'b0011_0001));
    @(negedge clk);
    reset = 1'b1;
    angle = 12'h0FF;
    step(5);
    angle = 12'h1FF;
    step(1);
    angle = 12'h100;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (dut.ang_s == 12'h1FF) bad++;
      step(1);
    end
    check("t6_torn_rejected", bad, 0);
    check("t6_ang_s_final", int'(dut.ang_s), 'h100);
    check("t6_idle_after_reset", int'({busy, cmd_ready}), 1);

    step(5);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
